au_div_sequencer: RTL and testbench



---
 rtl/au_div_sequencer_pkg.sv | 21 ++
 rtl/au_div_sequencer_au.sv | 49 ++++
 rtl/au_div_sequencer.sv | 121 ++++++++++++
 tb/tb_au_div_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/au_div_sequencer_pkg.sv
// Shared definitions for the divide sequencer and its arithmetic unit.
//   - AU opcode constants selecting A+B, A+1, A-B, A-1
//   - FSM state encoding for the sequencer
package au_div_sequencer_pkg;

    localparam int AU_WIDTH = 8;

    localparam logic [1:0] AU_ADD = 2'b00;
    localparam logic [1:0] AU_INC = 2'b01;
    localparam logic [1:0] AU_SUB = 2'b10;
    localparam logic [1:0] AU_DEC = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TEST = 3'd1,
        ST_SUB  = 3'd2,
        ST_INC  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/au_div_sequencer_au.sv
// arithmetic_unit: combinational 8-bit ALU shared by the divide sequencer.
// Ports:
//   i_a, i_b  [7:0]  operands
//   i_sel     [1:0]  00 A+B, 01 A+1, 10 A-B, 11 A-1
//   o_y       [7:0]  result
//   o_nzvc    [3:0]  {negative, zero, signed overflow, carry/borrow}
module arithmetic_unit
    import au_div_sequencer_pkg::*;
(
    input  logic [AU_WIDTH-1:0] i_a,
    input  logic [AU_WIDTH-1:0] i_b,
    input  logic [1:0]          i_sel,
    output logic [AU_WIDTH-1:0] o_y,
    output logic [3:0]          o_nzvc
);

    logic [AU_WIDTH:0] w_ext;
    logic              w_v;

    always_comb begin
        w_ext = '0;
        w_v   = 1'b0;
        case (i_sel)
            AU_ADD: begin
                w_ext = {1'b0, i_a} + {1'b0, i_b};
                w_v   = (i_a[AU_WIDTH-1] == i_b[AU_WIDTH-1]) &&
                        (w_ext[AU_WIDTH-1] != i_a[AU_WIDTH-1]);
            end
            AU_INC: begin
                w_ext = {1'b0, i_a} + 9'd1;
                w_v   = (i_a == 8'h7F);
            end
            AU_SUB: begin
                // Bit 8 of the 9-bit difference is the borrow out.
                w_ext = {1'b0, i_a} - {1'b0, i_b};
                w_v   = (i_a[AU_WIDTH-1] != i_b[AU_WIDTH-1]) &&
                        (w_ext[AU_WIDTH-1] != i_a[AU_WIDTH-1]);
            end
            default: begin
                w_ext = {1'b0, i_a} - 9'd1;
                w_v   = (i_a == 8'h80);
            end
        endcase
    end

    assign o_y    = w_ext[AU_WIDTH-1:0];
    assign o_nzvc = {w_ext[AU_WIDTH-1], (w_ext[AU_WIDTH-1:0] == '0), w_v, w_ext[AU_WIDTH]};

endmodule

// File: rtl/au_div_sequencer.sv
// au_div_sequencer: multi-cycle unsigned 8-bit divider by repeated
// subtraction, time-sharing one arithmetic_unit between the remainder
// (A-B) and quotient (A+1) updates.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               request, accepted only in IDLE
//   dividend, divisor   operands, latched when start is accepted
//   busy                high in every state except IDLE
//   done                one-cycle pulse while in DONE
//   quotient, remainder registered results (intermediate while busy)
//   div_by_zero         registered error flag
module au_div_sequencer
    import au_div_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic [WIDTH-1:0] w_au_a;
    logic [WIDTH-1:0] w_au_b;
    logic [1:0]       w_au_sel;
    logic [WIDTH-1:0] w_au_y;

    // Flags are not needed: the loop decision is a local compare in TEST.
    arithmetic_unit u_au (
        .i_a    (w_au_a),
        .i_b    (w_au_b),
        .i_sel  (w_au_sel),
        .o_y    (w_au_y),
        .o_nzvc ()
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_au_a       = '0;
        w_au_b       = '0;
        w_au_sel     = AU_ADD;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (divisor == '0) ? ST_DONE : ST_TEST;
                end
            end
            ST_TEST: begin
                w_state_next = (r_remainder >= r_divisor) ? ST_SUB : ST_DONE;
            end
            ST_SUB: begin
                w_au_a       = r_remainder;
                w_au_b       = r_divisor;
                w_au_sel     = AU_SUB;
                w_state_next = ST_INC;
            end
            ST_INC: begin
                w_au_a       = r_quotient;
                w_au_sel     = AU_INC;
                w_state_next = ST_TEST;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_divisor     <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_divisor     <= divisor;
                        r_remainder   <= dividend;
                        r_quotient    <= '0;
                        r_div_by_zero <= (divisor == '0);
                    end
                end
                ST_SUB:  r_remainder <= w_au_y;
                ST_INC:  r_quotient  <= w_au_y;
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_au_div_sequencer.sv
module tb_au_div_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    au_div_sequencer #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one start, count edges (start-sampling edge = 1) until done is
    // seen, then check latency, results and the return to IDLE.
    // With disturb set, a second start with other operands is pulsed on
    // edge 4 and must be ignored.
    task automatic run_op(input string name, input logic [7:0] dd, input logic [7:0] dv,
                          input int exp_edges, input int exp_q, input int exp_r,
                          input int exp_dbz, input bit disturb);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        while (n < 800 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                start = 1'b0;
                check({name, " busy_after_start"}, busy, 1);
            end
            if (disturb && n == 3) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end
            if (disturb && n == 4) begin
                start    = 1'b0;
                dividend = 8'd77;
                divisor  = 8'd7;
            end
            if (done) seen = 1'b1;
        end
        check({name, " done_seen"}, seen, 1);
        check({name, " latency"}, n, exp_edges);
        check({name, " quotient"}, quotient, exp_q);
        check({name, " remainder"}, remainder, exp_r);
        check({name, " div_by_zero"}, div_by_zero, exp_dbz);
        check({name, " busy_in_done"}, busy, 1);
        @(posedge clk);
        #1;
        check({name, " done_pulse_width"}, done, 0);
        check({name, " idle_after_done"}, busy, 0);
        check({name, " quotient_hold"}, quotient, exp_q);
        if (disturb) begin
            for (int k = 0; k < 4; k++) begin
                @(posedge clk);
                #1;
                check({name, " no_second_done"}, done, 0);
                check({name, " no_second_busy"}, busy, 0);
            end
            check({name, " remainder_hold"}, remainder, exp_r);
        end
        $display("op %s: %0d/%0d -> q=%0d r=%0d dbz=%0d after %0d edges",
                 name, dd, dv, quotient, remainder, div_by_zero, n);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_by_zero", div_by_zero, 0);
        $display("reset: busy=%0d done=%0d q=%0d r=%0d dbz=%0d",
                 busy, done, quotient, remainder, div_by_zero);
        @(negedge clk);
        rst = 1'b0;

        run_op("7/2",     8'd7,   8'd2,  11,   3,   1, 0, 1'b0);
        run_op("5/7",     8'd5,   8'd7,   2,   0,   5, 0, 1'b0);
        run_op("6/6",     8'd6,   8'd6,   5,   1,   0, 0, 1'b0);
        run_op("255/1",   8'd255, 8'd1, 767, 255,   0, 0, 1'b0);
        run_op("200/0",   8'd200, 8'd0,   1,   0, 200, 1, 1'b0);
        run_op("9/3",     8'd9,   8'd3,  11,   3,   0, 0, 1'b0);
        run_op("100/10",  8'd100, 8'd10, 32,  10,   0, 0, 1'b1);

        // Reset in the middle of 100/3: asserted for edge 10.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd3;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) start = 1'b0;
        end
        check("midrst busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst quotient", quotient, 0);
        check("midrst remainder", remainder, 0);
        $display("midrst: busy=%0d done=%0d q=%0d r=%0d", busy, done, quotient, remainder);

        run_op("8/4",     8'd8,   8'd4,   8,   2,   0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
